// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // IF/ID pipeline register payload.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid:    1'b0,
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0
    };

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_seq(input logic [XLEN-1:0] pc);
        return pc + XLEN'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble outranks hold, hold outranks load.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset_i,
    input  logic   hold_i,
    input  logic   bubble_i,
    input  if_id_t load_i,
    output if_id_t q_o
);

    if_id_t q_q;

    // Capture new payload, insert bubble, or keep current contents.
    always_ff @(posedge clk) begin
        if (reset_i || bubble_i) begin
            q_q <= IF_ID_BUBBLE;
        end else if (!hold_i) begin
            q_q <= load_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fault detection,
// RUN/FAULT state machine, fetch counter and the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    // First byte address past the end of instruction memory.
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(PC_STEP * IMEM_WORDS);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] count_q, count_d;

    logic            redirect_c;
    logic [XLEN-1:0] redirect_pc_c;
    logic            pc_bad_c;
    logic [XLEN-1:0] pc_seq_c;
    logic            ifid_hold_c;
    logic            ifid_bubble_c;
    if_id_t          ifid_load_c;
    if_id_t          ifid_q;

    // Branch belongs to the older instruction, so it wins over jump.
    always_comb begin
        redirect_c    = branch_taken | jump;
        redirect_pc_c = branch_taken ? branch_target : jump_target;
        pc_bad_c      = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
        pc_seq_c      = pc_seq(pc_q);
        ifid_load_c   = '{valid: 1'b1, instr: instruction, pc: pc_q, pc_plus4: pc_seq_c};
    end

    // Next-state, next-PC and IF/ID control selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_d       = fault_q;
        count_d       = count_q;
        ifid_hold_c   = 1'b1;
        ifid_bubble_c = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_c) begin
                    pc_d          = redirect_pc_c;
                    ifid_bubble_c = 1'b1;
                end else if (pc_bad_c) begin
                    state_d       = FAULT;
                    fault_d       = 1'b1;
                    ifid_bubble_c = 1'b1;
                end else if (stall) begin
                    ifid_bubble_c = flush;
                end else if (flush) begin
                    pc_d          = pc_seq_c;
                    ifid_bubble_c = 1'b1;
                end else begin
                    pc_d          = pc_seq_c;
                    ifid_hold_c   = 1'b0;
                    count_d       = count_q + 32'd1;
                end
            end
            FAULT: begin
                ifid_bubble_c = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // State, PC, sticky fault flag and fetch counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset_i  (reset),
        .hold_i   (ifid_hold_c),
        .bubble_i (ifid_bubble_c),
        .load_i   (ifid_load_c),
        .q_o      (ifid_q)
    );

    assign pc             = pc_q;
    assign if_id_valid    = ifid_q.valid;
    assign if_id_instr    = ifid_q.instr;
    assign if_id_pc       = ifid_q.pc;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign fetch_fault    = fault_q;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural pipeline model.
module tb_fetch_stage;

    localparam logic [31:0] W_A = 32'hAAAA_0001;
    localparam logic [31:0] W_B = 32'hBBBB_0002;
    localparam logic [31:0] W_C = 32'hCCCC_0003;
    localparam logic [31:0] W_D = 32'hDDDD_0004;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [16];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_fault;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_ipc4;
    logic [31:0] m_count;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .pc             (pc),
        .instruction    (instruction),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return garbage.
    always_comb begin
        if (pc[1:0] == 2'b00 && pc < 32'd64) instruction = mem[pc[5:2]];
        else                                 instruction = GARBAGE;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[1:0] == 2'b00 && a < 32'd64) return mem[a[5:2]];
        return GARBAGE;
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
    endtask

    // Advance the model by one edge using current inputs, then clock the DUT.
    task automatic tick();
        if (reset) begin
            m_pc = 32'h0; m_fault = 1'b0; m_count = 32'h0;
            model_bubble();
        end else if (m_fault) begin
            model_bubble();
        end else if (branch_taken) begin
            m_pc = branch_target; model_bubble();
        end else if (jump) begin
            m_pc = jump_target; model_bubble();
        end else if (m_pc % 4 != 0 || m_pc >= 64) begin
            m_fault = 1'b1; model_bubble();
        end else if (stall) begin
            if (flush) model_bubble();
        end else if (flush) begin
            m_pc = m_pc + 4; model_bubble();
        end else begin
            m_valid = 1'b1; m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 4;
            m_pc = m_pc + 4; m_count = m_count + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; reset = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = W_A; mem[1] = W_B; mem[2] = W_C; mem[3] = W_D;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick();
        reset = 0;
    endtask

    task automatic test_reset();
        fill_mem();
        idle_inputs();
        reset = 1; tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL reset_ifid got=%h/%h/%h exp=0/0/0", if_id_instr, if_id_pc, if_id_pc_plus4); end
        checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
            errors++; $display("FAIL reset_fault_count got=%b/%h exp=0/0", fetch_fault, fetch_count); end
        reset = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_w [4];
        exp_w[0] = W_A; exp_w[1] = W_B; exp_w[2] = W_C; exp_w[3] = W_D;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (pc !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, 32'(4 * (i + 1))); end
            checks++; if (if_id_valid !== 1'b1 || if_id_instr !== exp_w[i]) begin
                errors++; $display("FAIL seq_instr[%0d] got=%b/%h exp=1/%h", i, if_id_valid, if_id_instr, exp_w[i]); end
            checks++; if (if_id_pc !== 32'(4 * i) || if_id_pc_plus4 !== 32'(4 * i + 4)) begin
                errors++; $display("FAIL seq_ifpc[%0d] got=%h/%h exp=%h/%h", i, if_id_pc, if_id_pc_plus4, 32'(4 * i), 32'(4 * i + 4)); end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1;
        tick(); tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc got=%h exp=8", pc); end
        checks++; if (if_id_instr !== W_B || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL stall_ifid got=%h/%h exp=%h/4", if_id_instr, if_id_pc, W_B); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count got=%0d exp=2", fetch_count); end
        stall = 0;
        tick();
        checks++; if (if_id_instr !== W_C || if_id_pc !== 32'h8) begin
            errors++; $display("FAIL stall_release got=%h/%h exp=%h/8", if_id_instr, if_id_pc, W_C); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        tick(); tick(); tick();
        branch_taken = 1; branch_target = 32'h4;
        jump = 1; jump_target = 32'hC; stall = 1;
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL redir_pc got=%h exp=4", pc); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL redir_bubble got=%b/%h exp=0/0", if_id_valid, if_id_instr); end
        idle_inputs();
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== W_B || if_id_pc !== 32'h4) begin
            errors++; $display("FAIL redir_target got=%b/%h/%h exp=1/%h/4", if_id_valid, if_id_instr, if_id_pc, W_B); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL redir_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_fault_range();
        do_reset();
        for (int i = 0; i < 16; i++) tick();
        checks++; if (pc !== 32'h40 || fetch_fault !== 1'b0 || fetch_count !== 32'd16) begin
            errors++; $display("FAIL range_pre got=%h/%b/%0d exp=40/0/16", pc, fetch_fault, fetch_count); end
        tick();
        checks++; if (fetch_fault !== 1'b1 || pc !== 32'h40 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL range_fault got=%b/%h/%b exp=1/40/0", fetch_fault, pc, if_id_valid); end
        jump = 1; jump_target = 32'h0;
        tick(); tick();
        jump = 0;
        tick();
        checks++; if (fetch_fault !== 1'b1 || pc !== 32'h40 || if_id_valid !== 1'b0 || fetch_count !== 32'd16) begin
            errors++; $display("FAIL range_sticky got=%b/%h/%b/%0d exp=1/40/0/16", fetch_fault, pc, if_id_valid, fetch_count); end
        reset = 1; tick(); reset = 0;
        checks++; if (pc !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL range_reset got=%h/%b exp=0/0", pc, fetch_fault); end
    endtask

    task automatic test_misaligned_jump();
        do_reset();
        tick();
        jump = 1; jump_target = 32'h6;
        tick();
        checks++; if (pc !== 32'h6 || fetch_fault !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL misal_accept got=%h/%b/%b exp=6/0/0", pc, fetch_fault, if_id_valid); end
        jump = 0;
        tick();
        checks++; if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'h6) begin
            errors++; $display("FAIL misal_fault got=%b/%b/%h exp=1/0/6", fetch_fault, if_id_valid, pc); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        tick(); tick(); tick();
        stall = 1; flush = 1;
        tick();
        checks++; if (pc !== 32'hC || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            errors++; $display("FAIL flstall got=%h/%b/%h exp=C/0/0", pc, if_id_valid, if_id_instr); end
        idle_inputs();
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== W_D || if_id_pc !== 32'hC) begin
            errors++; $display("FAIL flstall_next got=%b/%h/%h exp=1/%h/C", if_id_valid, if_id_instr, if_id_pc, W_D); end
        flush = 1;
        tick();
        checks++; if (pc !== 32'h14 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_only got=%h/%b exp=14/0", pc, if_id_valid); end
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 99) < 3);
            stall         = ($urandom_range(0, 99) < 25);
            flush         = ($urandom_range(0, 99) < 15);
            branch_taken  = ($urandom_range(0, 99) < 8);
            jump          = ($urandom_range(0, 99) < 8);
            branch_target = ($urandom_range(0, 3) != 0) ? {26'h0, 4'($urandom_range(0, 15)), 2'b00} : 32'($urandom_range(0, 80));
            jump_target   = ($urandom_range(0, 3) != 0) ? {26'h0, 4'($urandom_range(0, 15)), 2'b00} : 32'($urandom_range(0, 80));
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc, m_pc); end
            checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, if_id_valid, m_valid); end
            checks++; if (if_id_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d] got=%h exp=%h", n, if_id_instr, m_instr); end
            checks++; if (if_id_pc !== m_ipc || if_id_pc_plus4 !== m_ipc4) begin
                errors++; $display("FAIL rnd_ifpc[%0d] got=%h/%h exp=%h/%h", n, if_id_pc, if_id_pc_plus4, m_ipc, m_ipc4); end
            checks++; if (fetch_fault !== m_fault) begin errors++; $display("FAIL rnd_fault[%0d] got=%b exp=%b", n, fetch_fault, m_fault); end
            checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, fetch_count, m_count); end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = 32'h0; m_fault = 1'b0; m_count = 32'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_priority();
        test_fault_range();
        test_misaligned_jump();
        test_flush_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
